// File: rtl/burst_sched_rr_pkg.sv
// Shared types for the round-robin burst scheduler: burst encoding, FSM states
// and the latched burst request, plus small address helpers.
package burst_sched_rr_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    XFER,
    DONE
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    burst_t      burst;
    logic [2:0]  prot;
    logic        write;
  } burst_req_t;

  function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] mask;
    mask = (32'd1 << size) - 32'd1;
    return addr & ~mask;
  endfunction

  // Only power-of-two beat counts form a valid wrap window.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/burst_sched_rr_if.sv
// Beat bus between the scheduler (master) and the APB master it feeds (slave).
interface burst_sched_rr_if;
  logic        beat_valid_o;
  logic        beat_ready_i;
  logic [31:0] beat_addr_o;
  logic        beat_last_o;
  logic        write_o;
  logic [2:0]  prot_o;

  modport master (
    output beat_valid_o,
    output beat_addr_o,
    output beat_last_o,
    output write_o,
    output prot_o,
    input  beat_ready_i
  );

  modport slave (
    input  beat_valid_o,
    input  beat_addr_o,
    input  beat_last_o,
    input  write_o,
    input  prot_o,
    output beat_ready_i
  );
endinterface

// File: rtl/burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module burst_addr_gen
  import burst_sched_rr_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [7:0]  len,
  input  logic [2:0]  size,
  input  burst_t      burst,
  output logic [31:0] next_addr
);

  logic [31:0] step;
  logic [31:0] incr;
  logic [31:0] wrap_mask;

  always_comb begin
    step      = 32'd1 << size;
    incr      = addr + step;
    // Window is (len+1) beats of 2^size bytes; len is pre-checked to be 2^n-1.
    wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    next_addr = incr;
    case (burst)
      FIXED:   next_addr = addr;
      WRAP:    next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default: next_addr = incr;
    endcase
  end

endmodule

// File: rtl/burst_sched_rr.sv
// Round-robin scheduler: picks one request channel, latches its burst and
// streams beat addresses to the APB master until the last beat is accepted.
module burst_sched_rr
  import burst_sched_rr_pkg::*;
#(
  parameter int                 NUM_CH     = 2,
  parameter logic [NUM_CH-1:0]  CH_DIR     = 2'b10,
  parameter int                 DATA_BYTES = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NUM_CH-1:0]     req_valid_i,
  input  logic [NUM_CH*32-1:0]  req_addr_i,
  input  logic [NUM_CH*8-1:0]   req_len_i,
  input  logic [NUM_CH*3-1:0]   req_size_i,
  input  logic [NUM_CH*2-1:0]   req_burst_i,
  input  logic [NUM_CH*3-1:0]   req_prot_i,
  input  logic [NUM_CH-1:0]     data_rdy_i,
  output logic [NUM_CH-1:0]     req_pop_o,
  output logic [NUM_CH-1:0]     grant_o,
  output logic                  burst_done_o,
  output logic                  err_o,
  burst_sched_rr_if.master      beat
);

  localparam int         CH_W     = $clog2(NUM_CH);
  localparam logic [2:0] MAX_SIZE = (DATA_BYTES >= 4) ? 3'd2 :
                                    (DATA_BYTES == 2) ? 3'd1 : 3'd0;

  state_t            state;
  state_t            state_nx;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   gidx;
  logic [CH_W-1:0]   win_idx;
  logic [NUM_CH-1:0] grant_q;
  burst_req_t        cur;
  burst_req_t        win_req;
  logic              win_err;
  logic              err_q;
  logic [7:0]        cnt;
  logic [31:0]       next_addr;
  logic              beat_valid;
  logic              last_beat;
  logic              accept;

  // Round-robin search starting just after the previously served channel.
  always_comb begin
    logic found;
    int   c;
    found   = 1'b0;
    c       = 0;
    win_idx = last_grant;
    for (int i = 1; i <= NUM_CH; i++) begin
      c = int'(last_grant) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!found && req_valid_i[CH_W'(c)]) begin
        found   = 1'b1;
        win_idx = CH_W'(c);
      end
    end
  end

  // Winner's request with illegal fields repaired before it is latched.
  always_comb begin
    logic [7:0]  rlen;
    logic [2:0]  rsize;
    logic [1:0]  rburst;
    rlen          = req_len_i[win_idx*8 +: 8];
    rsize         = req_size_i[win_idx*3 +: 3];
    rburst        = req_burst_i[win_idx*2 +: 2];
    win_err       = 1'b0;
    win_req       = '0;
    win_req.len   = rlen;
    win_req.prot  = req_prot_i[win_idx*3 +: 3];
    win_req.write = CH_DIR[win_idx];
    win_req.size  = rsize;
    if (rsize > MAX_SIZE) begin
      win_req.size = MAX_SIZE;
      win_err      = 1'b1;
    end
    win_req.burst = burst_t'(rburst);
    if (rburst == 2'b11) begin
      win_req.burst = INCR;
      win_err       = 1'b1;
    end else if ((rburst == 2'b10) && !wrap_len_ok(rlen)) begin
      win_req.burst = INCR;
      win_err       = 1'b1;
    end
    win_req.addr = align_addr(req_addr_i[win_idx*32 +: 32], win_req.size);
  end

  burst_addr_gen u_addr_gen (
    .addr      (cur.addr),
    .len       (cur.len),
    .size      (cur.size),
    .burst     (cur.burst),
    .next_addr (next_addr)
  );

  assign beat_valid = (state == XFER) && data_rdy_i[gidx];
  assign last_beat  = beat_valid && (cnt == cur.len);
  assign accept     = beat_valid && beat.beat_ready_i;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req_valid_i) state_nx = GRANT;
      GRANT:   state_nx = XFER;
      XFER:    if (accept && last_beat) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      last_grant <= CH_W'(NUM_CH - 1);
      gidx       <= '0;
      grant_q    <= '0;
      cur        <= '0;
      cnt        <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid_i) begin
            gidx    <= win_idx;
            grant_q <= NUM_CH'(1) << win_idx;
            cur     <= win_req;
            err_q   <= win_err;
          end
        end
        GRANT: cnt <= '0;
        XFER: begin
          if (accept) begin
            cnt      <= cnt + 8'd1;
            cur.addr <= next_addr;
          end
        end
        DONE: begin
          last_grant <= gidx;
          grant_q    <= '0;
          cur.write  <= 1'b0;
          cur.prot   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign grant_o           = grant_q;
  assign req_pop_o         = (state == DONE) ? grant_q : '0;
  assign burst_done_o      = (state == DONE);
  assign err_o             = err_q;
  assign beat.beat_valid_o = beat_valid;
  assign beat.beat_addr_o  = cur.addr;
  assign beat.beat_last_o  = last_beat;
  assign beat.write_o      = cur.write;
  assign beat.prot_o       = cur.prot;

  a_grant_onehot0: assert property (@(posedge aclk) disable iff (!aresetn) $onehot0(grant_q));
  a_xfer_granted:  assert property (@(posedge aclk) disable iff (!aresetn)
                                    (state == XFER) |-> $onehot(grant_q));

endmodule

// File: tb/tb_burst_sched_rr.sv
// Bench for burst_sched_rr: transaction-level reference model, per-cycle
// comparison, directed scenarios with literal expectations, then random traffic.
module tb_burst_sched_rr;
  localparam int              N     = 2;
  localparam int              MAXSZ = 2;
  localparam logic [N-1:0]    DIR   = 2'b10;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_addr;
  logic [N*8-1:0]  req_len;
  logic [N*3-1:0]  req_size;
  logic [N*2-1:0]  req_burst;
  logic [N*3-1:0]  req_prot;
  logic [N-1:0]    data_rdy;
  logic [N-1:0]    req_pop;
  logic [N-1:0]    grant;
  logic            burst_done;
  logic            err;

  burst_sched_rr_if bus ();

  burst_sched_rr #(.NUM_CH(N), .CH_DIR(DIR), .DATA_BYTES(4)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .req_valid_i  (req_valid),
    .req_addr_i   (req_addr),
    .req_len_i    (req_len),
    .req_size_i   (req_size),
    .req_burst_i  (req_burst),
    .req_prot_i   (req_prot),
    .data_rdy_i   (data_rdy),
    .req_pop_o    (req_pop),
    .grant_o      (grant),
    .burst_done_o (burst_done),
    .err_o        (err),
    .beat         (bus)
  );

  always #5 aclk = ~aclk;

  // Reference model: phase 0 idle, 1 grant, 2 transfer, 3 done.
  int          m_phase = 0;
  int          m_last  = N - 1;
  int          m_gidx  = 0;
  int          m_len   = 0;
  int          m_beat  = 0;
  bit          m_errf  = 1'b0;
  bit          m_write = 1'b0;
  logic [2:0]  m_prot  = 3'd0;
  logic [31:0] m_addrs [256];

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_phase = 0;
      m_last  = N - 1;
      m_beat  = 0;
    end else begin
      case (m_phase)
        0: if (req_valid != 0) begin
          bit          found;
          logic [31:0] a, step, base, win;
          int          s, b;
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (!found && req_valid[c]) begin
              found  = 1'b1;
              m_gidx = c;
            end
          end
          a       = req_addr[m_gidx*32 +: 32];
          m_len   = int'(req_len[m_gidx*8 +: 8]);
          s       = int'(req_size[m_gidx*3 +: 3]);
          b       = int'(req_burst[m_gidx*2 +: 2]);
          m_prot  = req_prot[m_gidx*3 +: 3];
          m_write = DIR[m_gidx];
          m_errf  = 1'b0;
          if (s > MAXSZ) begin s = MAXSZ; m_errf = 1'b1; end
          if (b == 3) begin
            b = 1; m_errf = 1'b1;
          end else if (b == 2 && !(m_len == 1 || m_len == 3 || m_len == 7 || m_len == 15)) begin
            b = 1; m_errf = 1'b1;
          end
          step = 32'd1 << s;
          base = a - (a % step);
          win  = 32'(m_len + 1) * step;
          for (int k = 0; k <= m_len; k++) begin
            if (b == 0)      m_addrs[k] = base;
            else if (b == 1) m_addrs[k] = base + 32'(k) * step;
            else             m_addrs[k] = (base - base % win) + ((base % win) + 32'(k) * step) % win;
          end
          m_beat  = 0;
          m_phase = 1;
        end
        1: m_phase = 2;
        2: if (data_rdy[m_gidx] && bus.beat_ready_i) begin
          if (m_beat == m_len) m_phase = 3;
          m_beat++;
        end
        default: begin
          m_phase = 0;
          m_last  = m_gidx;
        end
      endcase
    end
  end

  int          total = 0;
  int          bad   = 0;
  logic [31:0] cap_addr [$];
  bit          cap_last [$];
  int          cap_grant [$];
  int          n_done = 0;
  int          n_pop  = 0;
  int          n_err  = 0;
  logic [N-1:0] prev_grant = '0;
  logic [N-1:0] pend = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] eg, ep;
    logic         ev, el;
    eg = (m_phase != 0) ? (N'(1) << m_gidx) : '0;
    ev = (m_phase == 2) && data_rdy[m_gidx];
    el = ev && (m_beat == m_len);
    ep = (m_phase == 3) ? eg : '0;
    chk("grant", 32'(grant), 32'(eg));
    chk("beat_valid", 32'(bus.beat_valid_o), 32'(ev));
    chk("beat_last", 32'(bus.beat_last_o), 32'(el));
    chk("req_pop", 32'(req_pop), 32'(ep));
    chk("burst_done", 32'(burst_done), 32'(m_phase == 3));
    chk("err", 32'(err), 32'((m_phase == 1) && m_errf));
    if (m_phase != 0) begin
      chk("write", 32'(bus.write_o), 32'(m_write));
      chk("prot", 32'(bus.prot_o), 32'(m_prot));
    end
    if (ev) chk("beat_addr", bus.beat_addr_o, m_addrs[m_beat]);
    if (bus.beat_valid_o && bus.beat_ready_i) begin
      cap_addr.push_back(bus.beat_addr_o);
      cap_last.push_back(bus.beat_last_o);
    end
    if (grant != 0 && prev_grant == 0)
      for (int c = 0; c < N; c++) if (grant[c]) cap_grant.push_back(c);
    prev_grant = grant;
    if (err) n_err++;
    if (burst_done) n_done++;
    if (req_pop != 0) n_pop++;
    pend = pend | req_pop;
  endtask

  // Compares the current cycle at its falling edge, returns 1 ns after the next rise.
  task automatic step();
    @(negedge aclk);
    compare_all();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_logs();
    cap_addr.delete();
    cap_last.delete();
    cap_grant.delete();
    n_done = 0;
    n_pop  = 0;
    n_err  = 0;
  endtask

  task automatic set_ch(input int c, input logic [31:0] a, input logic [7:0] l,
                        input logic [2:0] s, input logic [1:0] b, input logic [2:0] p);
    req_addr[c*32 +: 32] = a;
    req_len[c*8 +: 8]    = l;
    req_size[c*3 +: 3]   = s;
    req_burst[c*2 +: 2]  = b;
    req_prot[c*3 +: 3]   = p;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      step();
      k++;
    end
    chk("bursts_done", 32'(n_done), 32'(target));
  endtask

  task automatic wait_beats(input int target, input int budget);
    int k;
    k = 0;
    while (cap_addr.size() < target && k < budget) begin
      step();
      k++;
    end
    chk("beats_seen", 32'(cap_addr.size()), 32'(target));
  endtask

  task automatic chk_addrs(input string nm, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3);
    logic [31:0] e [4];
    e[0] = a0; e[1] = a1; e[2] = a2; e[3] = a3;
    chk({nm, "_count"}, 32'(cap_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < cap_addr.size()) chk(nm, cap_addr[i], e[i]);
  endtask

  task automatic rand_ch(input int c);
    logic [31:0] a;
    logic [7:0]  l;
    int          r;
    r = $urandom_range(0, 3);
    a = (r == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(0, 63))) : 32'($urandom);
    r = $urandom_range(0, 5);
    case (r)
      0: l = 8'd0;
      1: l = 8'd1;
      2: l = 8'd3;
      3: l = 8'd7;
      4: l = 8'd15;
      default: l = 8'($urandom_range(0, 20));
    endcase
    set_ch(c, a, l, 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
  endtask

  initial begin
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    req_size  = '0;
    req_burst = '0;
    req_prot  = '0;
    data_rdy  = '0;
    bus.beat_ready_i = 1'b0;
    aresetn   = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_beat_valid", 32'(bus.beat_valid_o), 0);
    chk("rst_beat_addr", bus.beat_addr_o, 0);
    chk("rst_beat_last", 32'(bus.beat_last_o), 0);
    chk("rst_write", 32'(bus.write_o), 0);
    chk("rst_prot", 32'(bus.prot_o), 0);
    chk("rst_req_pop", 32'(req_pop), 0);
    chk("rst_burst_done", 32'(burst_done), 0);
    chk("rst_err", 32'(err), 0);
    aresetn = 1'b1;
    step();

    // Both channels requesting: strict alternation starting at ch0.
    clear_logs();
    set_ch(0, 32'h0000_0100, 8'd1, 3'd2, 2'b01, 3'd1);
    set_ch(1, 32'h0000_0200, 8'd0, 3'd2, 2'b01, 3'd5);
    data_rdy = 2'b11;
    bus.beat_ready_i = 1'b1;
    req_valid = 2'b11;
    wait_done(4, 200);
    req_valid = 2'b00;
    chk("rr_grant_count", 32'(cap_grant.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < cap_grant.size()) chk("rr_grant_order", 32'(cap_grant[i]), 32'(i % 2));
    chk("rr_pop_count", 32'(n_pop), 4);
    step();

    // INCR from an unaligned start.
    clear_logs();
    set_ch(0, 32'h0000_1003, 8'd3, 3'd2, 2'b01, 3'd2);
    req_valid = 2'b01;
    wait_done(1, 100);
    req_valid = 2'b00;
    chk_addrs("incr_addr", 32'h1000, 32'h1004, 32'h1008, 32'h100C);
    if (cap_last.size() == 4) begin
      chk("incr_last_first", 32'(cap_last[0]), 0);
      chk("incr_last_final", 32'(cap_last[3]), 1);
    end
    chk("incr_err", 32'(n_err), 0);
    step();

    // WRAP inside a 16-byte window.
    clear_logs();
    set_ch(0, 32'h0000_2038, 8'd3, 3'd2, 2'b10, 3'd0);
    req_valid = 2'b01;
    wait_done(1, 100);
    req_valid = 2'b00;
    chk_addrs("wrap_addr", 32'h2038, 32'h203C, 32'h2030, 32'h2034);
    step();

    // Data path not ready for three cycles after the second beat.
    clear_logs();
    set_ch(0, 32'h0000_3000, 8'd3, 3'd2, 2'b01, 3'd0);
    req_valid = 2'b01;
    wait_beats(2, 50);
    data_rdy = 2'b00;
    repeat (3) begin
      step();
      chk("stall_valid", 32'(bus.beat_valid_o), 0);
      chk("stall_addr", bus.beat_addr_o, 32'h3008);
      chk("stall_count", 32'(cap_addr.size()), 2);
    end
    data_rdy = 2'b11;
    wait_done(1, 100);
    req_valid = 2'b00;
    chk_addrs("stall_addr_seq", 32'h3000, 32'h3004, 32'h3008, 32'h300C);
    step();

    // Reserved burst type falls back to INCR and flags an error.
    clear_logs();
    set_ch(0, 32'h0000_4000, 8'd1, 3'd2, 2'b11, 3'd0);
    req_valid = 2'b01;
    wait_done(1, 100);
    req_valid = 2'b00;
    chk("rsvd_err_pulses", 32'(n_err), 1);
    chk("rsvd_beats", 32'(cap_addr.size()), 2);
    if (cap_addr.size() == 2) begin
      chk("rsvd_addr0", cap_addr[0], 32'h4000);
      chk("rsvd_addr1", cap_addr[1], 32'h4004);
    end
    step();

    // Reset during the second beat of an 8-beat burst, then retry.
    clear_logs();
    set_ch(0, 32'h0000_5000, 8'd7, 3'd2, 2'b01, 3'd3);
    req_valid = 2'b01;
    wait_beats(1, 50);
    aresetn = 1'b0;
    #1;
    chk("abort_grant", 32'(grant), 0);
    chk("abort_beat_valid", 32'(bus.beat_valid_o), 0);
    chk("abort_beat_addr", bus.beat_addr_o, 0);
    chk("abort_beat_last", 32'(bus.beat_last_o), 0);
    chk("abort_write", 32'(bus.write_o), 0);
    chk("abort_prot", 32'(bus.prot_o), 0);
    chk("abort_req_pop", 32'(req_pop), 0);
    step();
    aresetn = 1'b1;
    chk("abort_no_pop", 32'(n_pop), 0);
    clear_logs();
    wait_done(1, 100);
    req_valid = 2'b00;
    chk("retry_beats", 32'(cap_addr.size()), 8);
    if (cap_addr.size() == 8) begin
      chk("retry_first", cap_addr[0], 32'h5000);
      chk("retry_final", cap_addr[7], 32'h501C);
    end
    chk("retry_pop", 32'(n_pop), 1);
    step();

    // Random traffic against the model.
    pend = '0;
    for (int c = 0; c < N; c++) rand_ch(c);
    for (int it = 0; it < 3000; it++) begin
      step();
      if (it == 1500) begin
        aresetn = 1'b0;
        step();
        step();
        aresetn = 1'b1;
        pend = '0;
      end
      for (int c = 0; c < N; c++) begin
        if (pend[c]) begin
          rand_ch(c);
          req_valid[c] = 1'($urandom_range(0, 1));
          pend[c] = 1'b0;
        end else begin
          if ($urandom_range(0, 15) == 0) rand_ch(c);
          if ($urandom_range(0, 7) == 0) req_valid[c] = ~req_valid[c];
        end
        data_rdy[c] = ($urandom_range(0, 3) != 0);
      end
      bus.beat_ready_i = ($urandom_range(0, 3) != 0);
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/burst_sched_rr.md
BURST_SCHED_RR -- requirements
Module: burst_sched_rr

Interface
REQ-001 Parameter NUM_CH, default 2: number of burst request channels; legal range 2..8.
REQ-002 Parameter CH_DIR, default 2'b10: per-channel direction; bit=1 means write channel, bit=0 means read channel.
REQ-003 Parameter DATA_BYTES, default 4: APB data width in bytes; legal values 1, 2, 4.
REQ-004 Port: aclk, input, 1, clock; all logic is on the rising edge.
REQ-005 Port: aresetn, input, 1, reset, asynchronous, active-low.
REQ-006 Port: req_valid_i, input, NUM_CH, channel request FIFO non-empty.
REQ-007 Port: req_addr_i, input, NUM_CH*32, per-channel burst address.
REQ-008 Port: req_len_i, input, NUM_CH*8, per-channel AxLEN.
REQ-009 Port: req_size_i, input, NUM_CH*3, per-channel AxSIZE.
REQ-010 Port: req_burst_i, input, NUM_CH*2, per-channel AxBURST.
REQ-011 Port: req_prot_i, input, NUM_CH*3, per-channel AxPROT.
REQ-012 Port: data_rdy_i, input, NUM_CH, channel data path ready (read FIFO not almost-full, or write FIFO not almost-empty).
REQ-013 Port: beat_ready_i, input, 1, APB master accepts the current beat.
REQ-014 Port: req_pop_o, output, NUM_CH, one-cycle pop of the channel request FIFO.
REQ-015 Port: grant_o, output, NUM_CH, one-hot active grant.
REQ-016 Port: beat_valid_o, output, 1, a beat is available.
REQ-017 Port: beat_addr_o, output, 32, beat address.
REQ-018 Port: beat_last_o, output, 1, final beat of the burst.
REQ-019 Port: write_o, output, 1, granted channel is a write channel.
REQ-020 Port: prot_o, output, 3, latched AxPROT.
REQ-021 Port: burst_done_o, output, 1, one-cycle pulse at burst completion.
REQ-022 Port: err_o, output, 1, one-cycle pulse on an illegal request.

Function
REQ-023 FSM states: IDLE, GRANT, XFER, DONE.
- IDLE -> GRANT when any req_valid_i bit is set.
- GRANT -> XFER unconditionally.
- XFER -> DONE when the last beat is accepted.
- DONE -> IDLE unconditionally.
REQ-024 Arbitration in IDLE is round-robin: search begins at (last_grant+1) mod NUM_CH; the first set req_valid_i bit wins.
REQ-025 grant_o, addr, len, size, burst, prot and write_o are registered on the IDLE->GRANT edge and held constant until IDLE; input changes mid-burst are ignored.
REQ-026 Latency: req_valid_i seen in cycle 0 gives grant_o in cycle 1 and beat_valid_o at the earliest in cycle 2.
REQ-027 beat_valid_o = (state==XFER) & data_rdy_i[granted]; a beat is accepted when beat_valid_o & beat_ready_i.
REQ-028 The beat counter clears at GRANT and increments on each accept; beat_last_o = beat_valid_o & (cnt==len); len=0 gives a single beat.
REQ-029 The start address is aligned down to 2^size; beat_addr_o is updated only on accept.
REQ-030 Address update on accept, by burst type:
- FIXED: address unchanged.
- INCR: address + 2^size, modulo 2^32.
- WRAP: address wraps within a (len+1)*2^size byte window aligned to that window.
REQ-031 Illegal requests, each pulsing err_o during GRANT:
- burst=2'b11: treated as INCR.
- WRAP with len not in {1,3,7,15}: treated as INCR.
- 2^size > DATA_BYTES: size clamped to log2(DATA_BYTES).
REQ-032 In DONE, req_pop_o[granted] and burst_done_o pulse for exactly one cycle, and last_grant is updated.
REQ-033 data_rdy_i low in XFER stalls the burst with no state or address change; beat_valid_o is held low.

Reset
REQ-034 Asynchronous reset clears all state: FSM=IDLE, last_grant=NUM_CH-1 (channel 0 wins first), grant_o=0, beat_valid_o=0, beat_addr_o=0, beat_last_o=0, write_o=0, prot_o=0, req_pop_o=0, burst_done_o=0, err_o=0.
REQ-035 Reset mid-burst aborts the burst with no pop; the request is retried after reset.

Structure
REQ-036 The shared parameter_pkg holds the burst-type enum (FIXED/INCR/WRAP/RSVD), the FSM state enum, and a burst-request struct.
REQ-037 Address computation is a sub-module, burst_addr_gen: combinational next-address logic from addr, len, size and burst.

Verification
REQ-038 Scenario: ch0 INCR, addr 0x1003, len 3, size 2 -> beat addresses 0x1000, 0x1004, 0x1008, 0x100C; beat_last_o on the 4th beat.
REQ-039 Scenario: WRAP, addr 0x2038, len 3, size 2 -> beat addresses 0x2038, 0x203C, 0x2030, 0x2034.
REQ-040 Scenario: both channels requesting continuously for 4 bursts -> grant order ch0, ch1, ch0, ch1; one req_pop_o per burst.
REQ-041 Scenario: data_rdy_i dropped for 3 cycles mid-burst -> beat_valid_o low for those cycles; address and count held; burst completes correctly.
REQ-042 Scenario: burst=2'b11, len 1 -> err_o pulses in GRANT; addresses follow INCR.
REQ-043 Scenario: aresetn asserted during beat 2 of len 7 -> all outputs return to reset values immediately; no req_pop_o pulse.
